mountaincar_episode_ctrl: RTL and testbench
===========================================

MOUNTAINCAR_EPISODE_CTRL -- requirements
Module: mountaincar_episode_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- POS_WL, 32, position width (IEEE-754 single).
- VEL_WL, 32, velocity width (IEEE-754 single).
- ACT_WL, 2, action width.
- STEP_WL, 8, step counter width.
- MAX_STEPS, 200, truncation step limit.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset: synchronous, active-low.
- i_start, in, 1, begin new episode.
- i_init_pos, in, POS_WL, episode start position.
- i_act_valid, in, 1, agent action offered.
- i_act, in, ACT_WL, action 0/1/2.
- o_act_ready, out, 1, controller accepts action.
- o_cmp_ena, out, 1, enable to compute stage.
- o_cmp_pos, out, POS_WL, position to compute stage.
- o_cmp_vel, out, VEL_WL, velocity to compute stage.
- o_cmp_act, out, ACT_WL, action to compute stage.
- i_cmp_pos, in, POS_WL, next position from compute stage.
- i_cmp_vel, in, VEL_WL, next velocity from compute stage.
- i_cmp_rwd, in, 1, reward bit from compute stage.
- i_cmp_done, in, 1, goal reached.
- i_cmp_valid, in, 1, compute result valid.
- o_obs_pos, out, POS_WL, observed position.
- o_obs_vel, out, VEL_WL, observed velocity.
- o_obs_rwd, out, 1, observed reward.
- o_obs_done, out, 1, terminated.
- o_obs_trunc, out, 1, truncated.
- o_obs_valid, out, 1, one-cycle observation strobe.
- o_step_cnt, out, STEP_WL, steps taken this episode.
- o_err, out, 1, sticky watchdog error.

Function
REQ-003 FSM states SHALL be IDLE, READY, WAIT, EMIT, DONE.
REQ-004 IDLE or DONE with i_start=1: load pos=i_init_pos, vel=0x00000000, step=0, go to EMIT with rwd=0, done=0, trunc=0 (initial observation).
REQ-005 READY: o_act_ready=1; on i_act_valid&o_act_ready, latch action and go to WAIT next cycle; i_act=3 SHALL be latched as 1.
REQ-006 WAIT: o_cmp_ena=1; o_cmp_pos/vel/act SHALL be held stable from the latched registers; i_cmp_valid is ignored in all other states.
REQ-007 WAIT with i_cmp_valid=1: capture i_cmp_pos/vel/rwd/done into state registers, step=step+1 (saturating at all ones), go to EMIT; o_cmp_ena SHALL be 0 the following cycle so the compute stage restarts.
REQ-008 EMIT: o_obs_valid=1 for exactly one cycle with registered state; o_obs_trunc=1 when step==MAX_STEPS and done=0; next state DONE if done|trunc, else READY.
REQ-009 o_obs_* and o_step_cnt SHALL hold their last values between strobes.
REQ-010 i_start in READY, WAIT or EMIT SHALL be ignored; i_start and i_act_valid in the same READY cycle: the action is taken.
REQ-011 Latency: action accepted at cycle N -> o_cmp_ena rises at N+1; i_cmp_valid at cycle M -> o_obs_valid at M+1.
REQ-012 When both done and step==MAX_STEPS, o_obs_done=1 and o_obs_trunc=0.

Reset
REQ-013 i_rst_n=0 at a clock edge SHALL force IDLE; o_act_ready, o_cmp_ena, o_obs_valid, o_obs_done, o_obs_trunc, o_obs_rwd, o_err SHALL be 0; all data outputs and o_step_cnt SHALL be 0; reset SHALL apply in any state, including mid-WAIT.

Configuration
REQ-014 With MC_WATCHDOG_EN defined, a 10-bit counter SHALL run in WAIT; after 1024 cycles without i_cmp_valid, o_err SHALL be set (sticky until reset) and the FSM SHALL go to IDLE with o_cmp_ena=0.
REQ-015 Without MC_WATCHDOG_EN, no counter SHALL be built, o_err SHALL be tied 0, and WAIT SHALL have no timeout.

Verification
REQ-016 Reset, then i_start with i_init_pos=0xbef2ae91 -> one o_obs_valid; obs_pos=0xbef2ae91, obs_vel=0, step=0, o_act_ready=1.
REQ-017 Action 2, then compute returns pos=0xbef25c16, vel=0x3a24f712 -> o_cmp_pos=0xbef2ae91, o_cmp_act=2; obs matches returned values; step=1.
REQ-018 Run 200 steps with i_cmp_done=0 -> 200th obs has trunc=1; FSM enters DONE; o_act_ready=0.
REQ-019 i_cmp_done=1 at step 5 -> obs_done=1, trunc=0; a later i_start reloads with step=0.
REQ-020 i_act=3 -> o_cmp_act=1; i_rst_n=0 during WAIT -> all outputs 0 on the next cycle.
REQ-021 With MC_WATCHDOG_EN, withhold i_cmp_valid for 1024 cycles -> o_err=1, state IDLE; without the macro -> remains in WAIT, o_err=0.

Source files
------------

// File: rtl/mountaincar_episode_ctrl.sv
// mountaincar_episode_ctrl: episode sequencer for the mountain-car env; optional WAIT watchdog via MC_WATCHDOG_EN
module mountaincar_episode_ctrl #(
  parameter int POS_WL    = 32,
  parameter int VEL_WL    = 32,
  parameter int ACT_WL    = 2,
  parameter int STEP_WL   = 8,
  parameter int MAX_STEPS = 200
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [POS_WL-1:0]  i_init_pos,
  input  logic               i_act_valid,
  input  logic [ACT_WL-1:0]  i_act,
  output logic               o_act_ready,
  output logic               o_cmp_ena,
  output logic [POS_WL-1:0]  o_cmp_pos,
  output logic [VEL_WL-1:0]  o_cmp_vel,
  output logic [ACT_WL-1:0]  o_cmp_act,
  input  logic [POS_WL-1:0]  i_cmp_pos,
  input  logic [VEL_WL-1:0]  i_cmp_vel,
  input  logic               i_cmp_rwd,
  input  logic               i_cmp_done,
  input  logic               i_cmp_valid,
  output logic [POS_WL-1:0]  o_obs_pos,
  output logic [VEL_WL-1:0]  o_obs_vel,
  output logic               o_obs_rwd,
  output logic               o_obs_done,
  output logic               o_obs_trunc,
  output logic               o_obs_valid,
  output logic [STEP_WL-1:0] o_step_cnt,
  output logic               o_err
);
  typedef enum logic [2:0] {IDLE, READY, WAIT, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [POS_WL-1:0] pos_q, pos_d;
  logic [VEL_WL-1:0] vel_q, vel_d;
  logic [ACT_WL-1:0] act_q, act_d;
  logic [STEP_WL-1:0] step_q, step_d;
  logic rwd_q, rwd_d, done_q, done_d;
  logic trunc, timeout;
  // The episode registers only change on entry to EMIT, so they double as the held observation.
  assign trunc       = step_q == STEP_WL'(MAX_STEPS) && !done_q;
  assign o_act_ready = state_q == READY;
  assign o_cmp_ena   = state_q == WAIT;
  assign o_obs_valid = state_q == EMIT;
  assign o_cmp_pos   = pos_q;
  assign o_cmp_vel   = vel_q;
  assign o_cmp_act   = act_q;
  assign o_obs_pos   = pos_q;
  assign o_obs_vel   = vel_q;
  assign o_obs_rwd   = rwd_q;
  assign o_obs_done  = done_q;
  assign o_obs_trunc = trunc;
  assign o_step_cnt  = step_q;
`ifdef MC_WATCHDOG_EN
  logic [9:0] wd_q, wd_d;
  logic err_q, err_d;
  assign timeout = state_q == WAIT && !i_cmp_valid && &wd_q;
  assign o_err   = err_q;
  // Count cycles spent in WAIT; expiry raises a sticky error.
  always_comb begin
    wd_d  = state_q == WAIT ? wd_q + 10'd1 : 10'd0;
    err_d = err_q | timeout;
  end
  // Watchdog registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif
  // Next-state and episode register updates.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    act_d   = act_q;
    step_d  = step_q;
    rwd_d   = rwd_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: if (i_start) begin
        pos_d   = i_init_pos;
        vel_d   = '0;
        step_d  = '0;
        rwd_d   = 1'b0;
        done_d  = 1'b0;
        state_d = EMIT;
      end
      READY: if (i_act_valid) begin
        act_d   = i_act == ACT_WL'(3) ? ACT_WL'(1) : i_act;
        state_d = WAIT;
      end
      WAIT: if (timeout) state_d = IDLE;
      else if (i_cmp_valid) begin
        pos_d   = i_cmp_pos;
        vel_d   = i_cmp_vel;
        rwd_d   = i_cmp_rwd;
        done_d  = i_cmp_done;
        step_d  = &step_q ? step_q : step_q + STEP_WL'(1);
        state_d = EMIT;
      end
      EMIT: state_d = done_q || trunc ? DONE : READY;
      default: state_d = IDLE;
    endcase
  end
  // State and episode registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pos_q   <= '0;
      vel_q   <= '0;
      act_q   <= '0;
      step_q  <= '0;
      rwd_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      act_q   <= act_d;
      step_q  <= step_d;
      rwd_q   <= rwd_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_mountaincar_episode_ctrl.sv
// tb_mountaincar_episode_ctrl: scoreboard bench for mountaincar_episode_ctrl
module tb_mountaincar_episode_ctrl;
  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_act_valid = 0;
  logic i_cmp_rwd = 0, i_cmp_done = 0, i_cmp_valid = 0;
  logic [31:0] i_init_pos = 0, i_cmp_pos = 0, i_cmp_vel = 0;
  logic [1:0] i_act = 0;
  logic o_act_ready, o_cmp_ena, o_obs_rwd, o_obs_done, o_obs_trunc, o_obs_valid, o_err;
  logic [31:0] o_cmp_pos, o_cmp_vel, o_obs_pos, o_obs_vel;
  logic [1:0] o_cmp_act;
  logic [7:0] o_step_cnt;
  typedef struct {
    logic [31:0] pos, vel;
    logic rwd, done, trunc;
    logic [7:0] step;
  } obs_t;
  obs_t exp_q[$];
  int total = 0, bad = 0;
  logic [31:0] m_pos, m_vel;
  int m_step;
  bit m_end;

  mountaincar_episode_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_init_pos(i_init_pos),
    .i_act_valid(i_act_valid), .i_act(i_act), .o_act_ready(o_act_ready),
    .o_cmp_ena(o_cmp_ena), .o_cmp_pos(o_cmp_pos), .o_cmp_vel(o_cmp_vel), .o_cmp_act(o_cmp_act),
    .i_cmp_pos(i_cmp_pos), .i_cmp_vel(i_cmp_vel), .i_cmp_rwd(i_cmp_rwd),
    .i_cmp_done(i_cmp_done), .i_cmp_valid(i_cmp_valid),
    .o_obs_pos(o_obs_pos), .o_obs_vel(o_obs_vel), .o_obs_rwd(o_obs_rwd),
    .o_obs_done(o_obs_done), .o_obs_trunc(o_obs_trunc), .o_obs_valid(o_obs_valid),
    .o_step_cnt(o_step_cnt), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every observation strobe must match the oldest expected observation.
  always @(negedge i_clk) begin
    if (o_obs_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL obs_unexpected: got strobe step=%0d want none", o_step_cnt);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        chk("obs_pos", o_obs_pos, e.pos);
        chk("obs_vel", o_obs_vel, e.vel);
        chk("obs_rwd", 32'(o_obs_rwd), 32'(e.rwd));
        chk("obs_done", 32'(o_obs_done), 32'(e.done));
        chk("obs_trunc", 32'(o_obs_trunc), 32'(e.trunc));
        chk("obs_step", 32'(o_step_cnt), 32'(e.step));
      end
    end
  end

  task automatic check_reset();
    chk("rst_ready", 32'(o_act_ready), 0);
    chk("rst_cmp_ena", 32'(o_cmp_ena), 0);
    chk("rst_obs_valid", 32'(o_obs_valid), 0);
    chk("rst_flags", {29'd0, o_obs_done, o_obs_trunc, o_obs_rwd}, 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_cmp_pos", o_cmp_pos, 0);
    chk("rst_cmp_vel", o_cmp_vel, 0);
    chk("rst_cmp_act", 32'(o_cmp_act), 0);
    chk("rst_obs_pos", o_obs_pos, 0);
    chk("rst_obs_vel", o_obs_vel, 0);
    chk("rst_step", 32'(o_step_cnt), 0);
  endtask

  task automatic start_ep(input logic [31:0] p);
    obs_t e;
    @(negedge i_clk);
    i_start = 1;
    i_init_pos = p;
    m_pos = p; m_vel = 0; m_step = 0; m_end = 0;
    e = '{p, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    i_start = 0;
  endtask

  // Offer an action when ready, with stray start/compute noise that must be ignored.
  task automatic accept(input logic [1:0] a, output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge i_clk);
      if (o_act_ready === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got o_act_ready=%b want 1 within 10 cycles", o_act_ready);
      return;
    end
    chk("hold_step", 32'(o_step_cnt), 32'(m_step));
    chk("hold_pos", o_obs_pos, m_pos);
    i_act_valid = 1; i_act = a;
    i_start = 1'($urandom);
    i_cmp_valid = 1'($urandom); i_cmp_pos = $urandom; i_cmp_vel = $urandom;
    i_cmp_done = 1; i_cmp_rwd = 1;
    @(posedge i_clk); #1;
    i_act_valid = 0; i_start = 0; i_cmp_valid = 0; i_cmp_done = 0; i_cmp_rwd = 0;
    chk("cmp_ena_rise", 32'(o_cmp_ena), 1);
    chk("cmp_pos", o_cmp_pos, m_pos);
    chk("cmp_vel", o_cmp_vel, m_vel);
    chk("cmp_act", 32'(o_cmp_act), a == 2'd3 ? 32'd1 : 32'(a));
  endtask

  task automatic respond(input logic [31:0] p, v, input logic r, d, input int dly);
    obs_t e;
    bit tr;
    repeat (dly) begin
      @(posedge i_clk); #1;
      chk("cmp_hold_pos", o_cmp_pos, m_pos);
    end
    i_cmp_valid = 1; i_cmp_pos = p; i_cmp_vel = v; i_cmp_rwd = r; i_cmp_done = d;
    m_step = m_step < 255 ? m_step + 1 : 255;
    m_pos = p; m_vel = v;
    tr = m_step == 200 && !d;
    m_end = d || tr;
    e = '{p, v, r, d, tr, 8'(m_step)};
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    i_cmp_valid = 0; i_cmp_done = 0; i_cmp_rwd = 0;
    chk("cmp_ena_fall", 32'(o_cmp_ena), 0);
  endtask

  task automatic step(input logic [1:0] a, input logic [31:0] p, v, input logic r, d, input int dly);
    bit ok;
    accept(a, ok);
    if (ok) respond(p, v, r, d, dly);
  endtask

  task automatic run_episode(input int done_at);
    for (int n = 0; n < 260 && !m_end; n++)
      step(2'($urandom), $urandom, $urandom, 1'($urandom), m_step + 1 == done_at, int'($urandom_range(0, 2)));
    @(posedge i_clk); #1;
    chk("done_ready_low", 32'(o_act_ready), 0);
    chk("done_hold_step", 32'(o_step_cnt), 32'(m_step));
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset();
    i_rst_n = 1;
    start_ep(32'hbef2ae91);
    @(posedge i_clk); #1;
    chk("init_ready", 32'(o_act_ready), 1);
    step(2'd2, 32'hbef25c16, 32'h3a24f712, 1'b0, 1'b0, 1);
    run_episode(0);
    chk("trunc_flag", 32'(o_obs_trunc), 1);
    start_ep($urandom);
    run_episode(5);
    chk("done_flag", 32'(o_obs_done), 1);
    start_ep($urandom);
    run_episode(200);
    chk("done_over_trunc", {30'd0, o_obs_done, o_obs_trunc}, 32'd2);
    start_ep($urandom);
    @(posedge i_clk); #1;
    accept(2'd3, ok);
    i_rst_n = 0;
    @(posedge i_clk); #1;
    check_reset();
    i_rst_n = 1;
    m_pos = 0; m_vel = 0; m_step = 0; m_end = 1;
    start_ep($urandom);
    accept(2'd1, ok);
    repeat (1000) @(posedge i_clk);
    #1;
    chk("wd_still_wait", 32'(o_cmp_ena), 1);
    repeat (30) @(posedge i_clk);
    #1;
`ifdef MC_WATCHDOG_EN
    chk("wd_err", 32'(o_err), 1);
    chk("wd_cmp_ena", 32'(o_cmp_ena), 0);
    chk("wd_ready", 32'(o_act_ready), 0);
`else
    chk("nowd_err", 32'(o_err), 0);
    chk("nowd_cmp_ena", 32'(o_cmp_ena), 1);
`endif
    repeat (2) @(posedge i_clk);
    #1;
    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
